reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  32 x 32-bit MIPS general-purpose register file feeding both ALU operands (a <- rs_data, b <- rt_data).
//  It takes the ALU/memory result back as the write-back value. It is the directly upstream stage of the ALU.
//  Two asynchronous read ports, one synchronous write port, and $zero hardwired to 0.
//  After reset a sequential clear engine zeroes every register, one per cycle, so the array maps onto FPGA RAM.
// PARAMETERS
//  DATA_W          32  register width in bits
//  ADDR_W          5   register index width; depth = 2**ADDR_W
//  CLEAR_ON_RESET  1   1: run the clear sweep after reset; 0: skip it, contents undefined after reset
// PORTS
//  clock     in   1       single clock, rising edge
//  reset     in   1       synchronous, active-high
//  rs_addr   in   ADDR_W  read port A index
//  rt_addr   in   ADDR_W  read port B index
//  rs_data   out  DATA_W  read port A data (to ALU a)
//  rt_data   out  DATA_W  read port B data (to ALU b)
//  wr_en     in   1       write strobe
//  rd_addr   in   ADDR_W  write index
//  wr_data   in   DATA_W  write-back data (ALU res or load data)
//  busy      out  1       clear sweep in progress; core must stall
//  dbg_addr  in   ADDR_W  debug/bench read index
//  dbg_data  out  DATA_W  debug read data
// BEHAVIOUR
//  - One clock (clock); reset is synchronous and active-high; everything updates only on the rising edge.
//  - FSM states: CLEAR, READY.
//  - Reset at a rising edge: state<=CLEAR and clr_idx<=0 (CLEAR_ON_RESET=1), or state<=READY (CLEAR_ON_RESET=0).
//  - CLEAR: each cycle with reset low, mem[clr_idx]<=0 and clr_idx<=clr_idx+1.
//  - CLEAR -> READY on the edge that clears index 2**ADDR_W-1. The sweep takes exactly 32 cycles after reset deasserts.
//  - Reset re-asserted mid-sweep: the sweep restarts at clr_idx=0. No partial-state carryover.
//  - busy = (state==CLEAR), decoded from the state register.
//  - Reset value of busy is 1 (CLEAR_ON_RESET=1) or 0 (CLEAR_ON_RESET=0).
//  - Read ports are combinational from the array. No registered outputs, so there is no reset value beyond the sweep.
//  - Index 0 reads 0 on any read port, always, regardless of array content.
//  - While busy, rs_data, rt_data and dbg_data read 0.
//  - Write: when state==READY, wr_en=1 and rd_addr!=0, mem[rd_addr]<=wr_data at the rising edge.
//  - Writes are ignored while busy, during reset, or when rd_addr==0.
//  - No write-to-read bypass. A read of the register being written returns the old value until the edge.
//    This is mandatory: wr_data depends combinationally on rs_data/rt_data through the ALU, so a bypass would form a loop.
//  - rs_addr==rt_addr is legal; both ports return identical data.
//  - Width rule: full DATA_W stored; no sign/zero manipulation here.
// STRUCTURE
//  - Shared package mips_pkg: DATA_W=32, REG_ADDR_W=5, REG_ZERO=5'd0, and the rf_state_t enum {RF_CLEAR, RF_READY}.
//  - Array: reg [DATA_W-1:0] mem[0:2**ADDR_W-1]; write in one clocked block; read muxes are continuous assigns.
//  - Optional sub-module rf_clear_seq: owns state and clr_idx; outputs busy, clr_we and clr_idx.
//    The array write mux selects the clear path when clr_we=1, else the core write path.
// TESTING
//  1. Pulse reset for 1 cycle -> busy=1 for exactly 32 rising edges after reset drops, then 0; dbg_data=0 for every dbg_addr 0..31.
//  2. When READY: wr_en=1, rd_addr=5, wr_data=32'hDEADBEEF -> same cycle rs_addr=5 reads the old value 0; next cycle reads 32'hDEADBEEF.
//  3. wr_en=1, rd_addr=0, wr_data=32'hFFFFFFFF -> rs_data=rt_data=dbg_data=0 with address 0 on every later cycle.
//  4. Write 32'h12345678 to reg 9, then re-assert reset at sweep cycle 10 -> busy stays 1 for 32 more cycles; reg 9 reads 0 afterwards.
//  5. wr_en=1, rd_addr=3, wr_data=32'hA5A5A5A5 during busy -> after READY, reg 3 reads 0.
//  6. rs_addr=rt_addr=7 after writing 32'h00000042 -> both rs_data and rt_data=32'h00000042.
//     Then write 7 with rs_addr=7 -> no combinational loop; stable old value until the edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: datapath width, register index width,
// the hardwired $zero index and the register-file clear-sweep states.
package mips_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_clear_seq.sv
// Register-file clear sequencer. After reset it walks every register index
// once, asserting clr_we so the array writes zero there, then settles in READY.
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high
//   busy    out  sweep in progress (state == CLEAR)
//   clr_we  out  write-zero strobe for the array
//   clr_idx out  index currently being cleared
module rf_clear_seq #(
  parameter int unsigned ADDR_W         = 5,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);
  import mips_pkg::*;

  rf_state_t         r_state;
  rf_state_t         w_next;
  logic [ADDR_W-1:0] r_clr_idx;

  // State register; a reset mid-sweep restarts the walk from index 0.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= CLEAR_ON_RESET ? RF_CLEAR : RF_READY;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == RF_CLEAR) begin
        r_clr_idx <= r_clr_idx + 1'b1;
      end
    end
  end

  // Next state: leave CLEAR on the edge that clears the last index.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RF_CLEAR: if (r_clr_idx == '1) w_next = RF_READY;
      default:  w_next = r_state;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    busy    = (r_state == RF_CLEAR);
    clr_we  = (r_state == RF_CLEAR) && !reset;
    clr_idx = r_clr_idx;
  end

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit MIPS general-purpose register file feeding the ALU operands.
// Two asynchronous read ports, one synchronous write port, a debug read port,
// $zero hardwired to 0, and a post-reset clear sweep so the array maps to RAM.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   rs_addr / rs_data      read port A (ALU a)
//   rt_addr / rt_data      read port B (ALU b)
//   wr_en, rd_addr, wr_data write-back port
//   busy                   clear sweep in progress; core must stall
//   dbg_addr / dbg_data    debug read port
module reg_file #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 5,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              busy,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  import mips_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_mem [0:2**ADDR_W-1];
  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_idx;
  logic              w_core_we;

  rf_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clock  (clock),
    .reset  (reset),
    .busy   (w_busy),
    .clr_we (w_clr_we),
    .clr_idx(w_clr_idx)
  );

  assign w_core_we = !reset && !w_busy && wr_en && (rd_addr != ZERO_IDX);

  // Single write port: the clear path has priority over core write-back.
  always_ff @(posedge clock) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_core_we) begin
      r_mem[rd_addr] <= wr_data;
    end
  end

  // Reads come straight from the array with no write bypass: wr_data depends
  // on rs_data/rt_data through the ALU, so a bypass would close a loop.
  assign rs_data  = (w_busy || rs_addr  == ZERO_IDX) ? '0 : r_mem[rs_addr];
  assign rt_data  = (w_busy || rt_addr  == ZERO_IDX) ? '0 : r_mem[rt_addr];
  assign dbg_data = (w_busy || dbg_addr == ZERO_IDX) ? '0 : r_mem[dbg_addr];
  assign busy     = w_busy;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs_addr, rt_addr, rd_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wr_data;
  logic        wr_en, busy;

  int unsigned total = 0;
  int unsigned bad   = 0;

  reg_file #(
    .DATA_W        (32),
    .ADDR_W        (5),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .wr_en   (wr_en),
    .rd_addr (rd_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Count edges from reset release until busy falls; expected to be 32.
  task automatic sweep_len(input string name);
    int unsigned cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
    check(name, 32'(cycles), 32'd32);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  initial begin
    reset = 1'b1; wr_en = 1'b0; rd_addr = '0; wr_data = '0;
    rs_addr = '0; rt_addr = '0; dbg_addr = '0;

    // 1. Reset, sweep length, cleared contents.
    tick();
    check("busy_after_reset", 32'(busy), 32'd1);
    reset = 1'b0;
    sweep_len("sweep_len_initial");
    check("busy_low_ready", 32'(busy), 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check("dbg_cleared", dbg_data, 32'd0);
    end

    // 2/3/6. Table of single-cycle vectors; reads sampled before the edge.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0, 32'h0,        32'h0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd5, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 5'd7,  32'h00000042, 5'd7,  5'd7, 32'h0,        32'h0};
    vecs[5] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd7, 32'h00000042, 32'h00000042};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5, 32'h11111111, 32'hDEADBEEF};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd0, 32'h0,        32'h0};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd0, 32'hFFFFFFFF, 32'h0};
    foreach (vecs[i]) begin
      wr_en = vecs[i].we; rd_addr = vecs[i].rd; wr_data = vecs[i].wd;
      rs_addr = vecs[i].rs; rt_addr = vecs[i].rt; dbg_addr = vecs[i].rs;
      #1;
      check("vec_rs", rs_data, vecs[i].exp_rs);
      check("vec_rt", rt_data, vecs[i].exp_rt);
      check("vec_dbg", dbg_data, vecs[i].exp_rs);
      tick();
    end
    wr_en = 1'b0;

    // 4. Reset re-asserted mid-sweep restarts the full sweep.
    wr_en = 1'b1; rd_addr = 5'd9;  wr_data = 32'h12345678; tick();
    rd_addr = 5'd20; wr_data = 32'hCAFEF00D; tick();
    wr_en = 1'b0; dbg_addr = 5'd20; #1;
    check("reg20_written", dbg_data, 32'hCAFEF00D);
    pulse_reset();
    for (int i = 0; i < 10; i++) tick();
    check("busy_mid_sweep", 32'(busy), 32'd1);
    check("dbg_zero_while_busy", dbg_data, 32'd0);
    pulse_reset();
    sweep_len("sweep_len_restart");
    dbg_addr = 5'd9;  #1; check("reg9_cleared", dbg_data, 32'd0);
    dbg_addr = 5'd20; #1; check("reg20_cleared", dbg_data, 32'd0);

    // 5. Writes during the sweep are ignored.
    pulse_reset();
    wr_en = 1'b1; rd_addr = 5'd3; wr_data = 32'hA5A5A5A5;
    sweep_len("sweep_len_busy_write");
    wr_en = 1'b0;
    rs_addr = 5'd3; #1;
    check("busy_write_ignored", rs_data, 32'd0);

    // Randomized traffic against an array model.
    foreach (model[i]) model[i] = 32'd0;
    for (int n = 0; n < 300; n++) begin
      wr_en    = 1'($urandom_range(0, 1));
      rd_addr  = 5'($urandom_range(0, 31));
      wr_data  = $urandom;
      rs_addr  = 5'($urandom_range(0, 31));
      rt_addr  = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
      dbg_addr = 5'($urandom_range(0, 31));
      #1;
      check("rand_rs", rs_data, mread(rs_addr));
      check("rand_rt", rt_data, mread(rt_addr));
      check("rand_dbg", dbg_data, mread(dbg_addr));
      tick();
      if (wr_en && rd_addr != 5'd0) model[rd_addr] = wr_data;
    end
    wr_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
